// File: rtl/pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// pll_lock_monitor : synchronises PLL lock/clkout0, tracks lock events and
//                    measures clkout0 frequency (macro PLL_MON_FREQ_CHECK_EN)
// Revision         : 1.0
// ============================================================================
module pll_lock_monitor #(
  parameter int WINDOW     = 1000,
  parameter int EXP_EDGES  = 50,
  parameter int TOL        = 2,
  parameter int SETTLE_CYC = 64
) (
  input  logic        clk_tb,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic        clkout0,
  output logic        lock_sync,
  output logic        lock_rise,
  output logic        lock_fall,
  output logic [1:0]  lock_cnt,
  output logic [15:0] freq_cnt,
  output logic        freq_valid,
  output logic        freq_err,
  output logic        err_chk,
  output logic [2:0]  results_cnt
);

  logic [2:0] ls;
  logic       freq_bad;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) ls <= '0;
    else        ls <= {ls[1:0], pll_lock};
  end

  assign lock_sync = ls[1];
  assign lock_rise = ls[1] & ~ls[2];
  assign lock_fall = ~ls[1] & ls[2];

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt    <= '0;
      err_chk     <= 1'b0;
      results_cnt <= '0;
    end else begin
      if (lock_rise && lock_cnt != 2'd3) lock_cnt <= lock_cnt + 2'd1;
      // Lock lost after first lock, any relock, or a bad window all flag an error.
      err_chk <= ((lock_cnt == 2'd1) && !lock_sync) || (lock_cnt >= 2'd2) || freq_bad;
      if (results_cnt == 3'b111) results_cnt <= 3'b100;
      else if (err_chk)          results_cnt <= results_cnt + 3'd1;
    end
  end

`ifdef PLL_MON_FREQ_CHECK_EN
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WW-1:0]     WIN_LAST    = WW'(WINDOW - 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic signed [16:0] EXP_S      = 17'(EXP_EDGES);
  localparam logic signed [16:0] TOL_S      = 17'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         cs;
  logic [SW-1:0]      settle_cnt;
  logic [WW-1:0]      win_cnt;
  logic [15:0]        edge_cnt;
  logic [15:0]        edge_next;
  logic               clk_edge;
  logic signed [16:0] dev;
  logic signed [16:0] dev_abs;
  logic               out_of_tol;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) cs <= '0;
    else        cs <= {cs[1:0], clkout0};
  end

  assign clk_edge = cs[1] & ~cs[2];

  // edge_next already includes an edge seen in the closing cycle of a window.
  always_comb begin
    edge_next = edge_cnt;
    if (clk_edge && edge_cnt != 16'hFFFF) edge_next = edge_cnt + 16'd1;
    dev        = $signed({1'b0, edge_next}) - EXP_S;
    dev_abs    = dev[16] ? -dev : dev;
    out_of_tol = dev_abs > TOL_S;
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
      freq_err   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_rise) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (lock_fall) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state    <= MEASURE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        MEASURE: begin
          // An abort takes priority over a window closing in the same cycle.
          if (lock_fall) begin
            state <= IDLE;
          end else if (win_cnt == WIN_LAST) begin
            freq_cnt   <= edge_next;
            freq_valid <= 1'b1;
            freq_err   <= out_of_tol;
            win_cnt    <= '0;
            edge_cnt   <= '0;
          end else begin
            win_cnt  <= win_cnt + WW'(1);
            edge_cnt <= edge_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign freq_bad = freq_valid & freq_err;
`else
  localparam int unused_params = WINDOW + EXP_EDGES + TOL + SETTLE_CYC;
  logic unused_clkout0;

  assign unused_clkout0 = clkout0;
  assign freq_cnt       = '0;
  assign freq_valid     = 1'b0;
  assign freq_err       = 1'b0;
  assign freq_bad       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
`timescale 1ns/1ps
// Bench for pll_lock_monitor: random lock/clock stimulus checked every cycle
// against a history-based model of the monitor's rules.
module tb_pll_lock_monitor;
  localparam int WINDOW     = 1000;
  localparam int EXP_EDGES  = 50;
  localparam int TOL        = 2;
  localparam int SETTLE_CYC = 64;

  logic        clk_tb;
  logic        rst_n;
  logic        pll_lock;
  logic        clkout0;
  logic        lock_sync, lock_rise, lock_fall;
  logic [1:0]  lock_cnt;
  logic [15:0] freq_cnt;
  logic        freq_valid, freq_err, err_chk;
  logic [2:0]  results_cnt;

  int checks = 0;
  int errors = 0;
  int ck_per = 20;
  int ph     = 0;

  pll_lock_monitor #(
    .WINDOW(WINDOW), .EXP_EDGES(EXP_EDGES), .TOL(TOL), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .clkout0(clkout0),
    .lock_sync(lock_sync), .lock_rise(lock_rise), .lock_fall(lock_fall),
    .lock_cnt(lock_cnt), .freq_cnt(freq_cnt), .freq_valid(freq_valid),
    .freq_err(freq_err), .err_chk(err_chk), .results_cnt(results_cnt)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Input history since reset release: index t = value sampled at the t-th clock edge.
  bit lq[$];
  bit cq[$];
  function automatic bit hl(int i);
    if (i < 0 || i >= lq.size()) return 1'b0;
    return lq[i];
  endfunction
  function automatic bit hc(int i);
    if (i < 0 || i >= cq.size()) return 1'b0;
    return cq[i];
  endfunction

  // Expected outputs after the most recent edge.
  bit e_sync, e_rise, e_fall, e_fv, e_fe, e_err;
  int e_lcnt, e_fc, e_res;
  int mode = 0;   // 0 idle, 1 settling, 2 measuring
  int t0   = 0;   // edge at which the current phase began

  task automatic model_step();
    bit p_sync, p_rise, p_fall, p_fv, p_fe, p_err;
    int p_lcnt, p_res, t, cnt, d;
    if (!rst_n) begin
      lq.delete(); cq.delete();
      e_sync = 0; e_rise = 0; e_fall = 0; e_fv = 0; e_fe = 0; e_err = 0;
      e_lcnt = 0; e_fc = 0; e_res = 0; mode = 0; t0 = 0;
      return;
    end
    p_sync = e_sync; p_rise = e_rise; p_fall = e_fall; p_fv = e_fv; p_fe = e_fe;
    p_err = e_err; p_lcnt = e_lcnt; p_res = e_res;
    lq.push_back(pll_lock);
    cq.push_back(clkout0);
    t = lq.size() - 1;

    e_res  = (p_res == 7) ? 4 : p_res + (p_err ? 1 : 0);
    e_err  = ((p_lcnt == 1) && !p_sync) || (p_lcnt >= 2);
    e_lcnt = (p_lcnt + (p_rise ? 1 : 0) > 3) ? 3 : p_lcnt + (p_rise ? 1 : 0);
    e_sync = hl(t - 1);
    e_rise = hl(t - 1) && !hl(t - 2);
    e_fall = !hl(t - 1) && hl(t - 2);
`ifdef PLL_MON_FREQ_CHECK_EN
    if (p_fv && p_fe) e_err = 1'b1;
    e_fv = 1'b0;
    if (mode != 0 && p_fall) begin
      mode = 0;
    end else if (mode == 0 && p_rise) begin
      mode = 1; t0 = t;
    end else if (mode == 1 && t - t0 == SETTLE_CYC) begin
      mode = 2; t0 = t;
    end else if (mode == 2 && (t - t0) % WINDOW == 0) begin
      cnt = 0;
      for (int e = t - WINDOW + 1; e <= t; e++)
        if (hc(e - 2) && !hc(e - 3)) cnt++;
      if (cnt > 65535) cnt = 65535;
      d    = cnt - EXP_EDGES;
      e_fc = cnt;
      e_fe = (d > TOL) || (d < -TOL);
      e_fv = 1'b1;
    end
`endif
  endtask

  initial forever begin
    @(posedge clk_tb);
    model_step();
  end

  initial forever begin
    @(negedge clk_tb);
    chk("lock_sync", lock_sync, e_sync);
    chk("lock_rise", lock_rise, e_rise);
    chk("lock_fall", lock_fall, e_fall);
    chk("lock_cnt", lock_cnt, e_lcnt);
    chk("freq_cnt", freq_cnt, e_fc);
    chk("freq_valid", freq_valid, e_fv);
    chk("freq_err", freq_err, e_fe);
    chk("err_chk", err_chk, e_err);
    chk("results_cnt", results_cnt, e_res);
  end

  // clkout0: high for the first half of each ck_per-cycle period.
  initial begin
    clkout0 = 1'b0;
    forever begin
      @(negedge clk_tb);
      ph = (ph + 1 >= ck_per) ? 0 : ph + 1;
      clkout0 = (ph < ck_per / 2);
    end
  end

  task automatic wait_fv(input int budget);
    int n = 0;
    do begin
      @(negedge clk_tb);
      n++;
    end while (freq_valid !== 1'b1 && n < budget);
    chk("wait_freq_valid", freq_valid, 1);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk_tb);
  endtask

  task automatic random_locks(input int iters);
    for (int i = 0; i < iters; i++) begin
      ck_per   = $urandom_range(4, 60);
      pll_lock = 1'b1;
      if ($urandom_range(0, 3) == 0) run($urandom_range(1, 4));
      else                           run($urandom_range(1100, 2600));
      pll_lock = 1'b0;
      run($urandom_range(1, 40));
    end
  endtask

  initial begin
    int nfv;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    run(2);
    #2 rst_n = 1'b1;

    // Idle with no lock: nothing counts.
    run(1000);
    chk("idle_results_cnt", results_cnt, 0);
    chk("idle_lock_cnt", lock_cnt, 0);

    // First lock: rise latency and width.
    pll_lock = 1'b1;
    @(negedge clk_tb); chk("rise_early", lock_rise, 0);
    @(negedge clk_tb); chk("rise_pulse", lock_rise, 1);
    @(negedge clk_tb); chk("rise_width", lock_rise, 0);
    chk("lock_cnt_first", lock_cnt, 1);

`ifdef PLL_MON_FREQ_CHECK_EN
    wait_fv(1200);
    chk("win1_freq_cnt", freq_cnt, 50);
    chk("win1_freq_err", freq_err, 0);
    wait_fv(1200);
    chk("win2_freq_cnt", freq_cnt, 50);
    chk("win2_err_chk", err_chk, 0);

    // Half-rate clkout0.
    ck_per = 40;
    wait_fv(1200);
    wait_fv(1200);
    chk("slow_freq_cnt", freq_cnt, 25);
    chk("slow_freq_err", freq_err, 1);

    // Drop lock so lock_fall lands on the last cycle of the window.
    run(997);
    pll_lock = 1'b0;
    nfv = 0;
    repeat (1100) begin
      @(negedge clk_tb);
      if (freq_valid) nfv++;
    end
    chk("abort_no_valid", nfv, 0);
    chk("abort_keep_cnt", freq_cnt, 25);
`else
    run(1500);
    chk("nofreq_cnt", freq_cnt, 0);
    chk("nofreq_err_chk", err_chk, 0);
    ck_per = 40;
    run(500);
    pll_lock = 1'b0;
    run(1100);
`endif
    chk("lost_lock_cnt", lock_cnt, 1);
    chk("lost_err_chk", err_chk, 1);

    // Relocks.
    pll_lock = 1'b1; run(10);
    chk("relock_cnt", lock_cnt, 2);
    chk("relock_err_chk", err_chk, 1);
    pll_lock = 1'b0; run(10);
    pll_lock = 1'b1; run(10);
    pll_lock = 1'b0; run(10);
    pll_lock = 1'b1; run(10);
    chk("lock_cnt_sat", lock_cnt, 3);

    random_locks(6);

    // Asynchronous reset in the middle of a window.
    ck_per   = 21;
    pll_lock = 1'b1;
    run(1500);
    #2 rst_n = 1'b0;
    run(2);
    #2 rst_n = 1'b1;
    @(negedge clk_tb);
    chk("reset_lock_cnt", lock_cnt, 0);
    chk("reset_results_cnt", results_cnt, 0);
    run(2300);
    chk("post_reset_lock_cnt", lock_cnt, 1);

    random_locks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
